seq_multiplier: RTL and testbench



---
 rtl/mul_pkg.sv | 15 +
 rtl/mul_cond_neg.sv | 12 +
 rtl/seq_multiplier.sv | 156 +++++++++++++++
 tb/tb_seq_multiplier.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // One extra bit so the step counter can also hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mul_cond_neg.sv
// Combinational conditional two's-complement negate of a W-bit value.
module mul_cond_neg #(
  parameter int W = 4
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative N-bit shift-add multiplier with valid/ready handshakes on both sides.
// Two's-complement mode is built only when SEQ_MUL_SIGNED_EN is defined.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out
);

  localparam int CNT_W = cnt_width(N);
  localparam int W2    = 2 * N;

  mul_state_e       state_r;
  mul_state_e       state_next_s;
  logic [W2-1:0]    mcand_r;
  logic [N-1:0]     mplier_r;
  logic [W2-1:0]    acc_r;
  logic [CNT_W-1:0] count_r;
  logic             neg_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [W2-1:0]    out_r;

  logic [N-1:0]     mag_a_s;
  logic [N-1:0]     mag_b_s;
  logic             neg_in_s;
  logic [W2-1:0]    addend_s;
  logic [W2-1:0]    acc_sum_s;
  logic [W2-1:0]    result_s;
  logic             accept_s;
  logic             last_step_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;

  assign accept_s    = in_valid && in_ready_r;
  assign last_step_s = (count_r == CNT_W'(N - 1));

`ifdef SEQ_MUL_SIGNED_EN
  // Magnitudes are N-bit unsigned, so the most negative operand maps exactly.
  mul_cond_neg #(.W(N)) u_neg_a (
    .val (a),
    .neg (signed_mode & a[N-1]),
    .res (mag_a_s)
  );

  mul_cond_neg #(.W(N)) u_neg_b (
    .val (b),
    .neg (signed_mode & b[N-1]),
    .res (mag_b_s)
  );

  mul_cond_neg #(.W(W2)) u_neg_out (
    .val (acc_sum_s),
    .neg (neg_r),
    .res (result_s)
  );

  assign neg_in_s = signed_mode & (a[N-1] ^ b[N-1]);
`else
  logic unused_s;

  assign mag_a_s  = a;
  assign mag_b_s  = b;
  assign neg_in_s = 1'b0;
  assign result_s = acc_sum_s;
  assign unused_s = signed_mode ^ neg_r;
`endif

  // Partial-product step and next-state selection.
  always_comb begin
    state_next_s = state_r;
    if (mplier_r[0]) begin
      addend_s = mcand_r << count_r;
    end else begin
      addend_s = {W2{1'b0}};
    end
    acc_sum_s = acc_r + addend_s;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (last_step_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= {W2{1'b0}};
      mcand_r     <= {W2{1'b0}};
      mplier_r    <= {N{1'b0}};
      acc_r       <= {W2{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      neg_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r  <= {{N{1'b0}}, mag_a_s};
            mplier_r <= mag_b_s;
            neg_r    <= neg_in_s;
            acc_r    <= {W2{1'b0}};
            count_r  <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          acc_r    <= acc_sum_s;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CNT_W'(1);
          if (last_step_s) begin
            out_r <= result_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=4) against an arithmetic reference model.
module tb_seq_multiplier;

  localparam int N  = 4;
  localparam int W2 = 2 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          signed_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W2-1:0] out;

  int n_checks = 0;
  int n_errors = 0;

  seq_multiplier #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer product of the interpreted operands, kept to 2N bits.
  function automatic logic [W2-1:0] ref_product(input logic [N-1:0] x, input logic [N-1:0] y,
                                                input logic sm);
    longint xi;
    longint yi;
    xi = longint'(x);
    yi = longint'(y);
`ifdef SEQ_MUL_SIGNED_EN
    if (sm && x[N-1]) xi = xi - (longint'(1) << N);
    if (sm && y[N-1]) yi = yi - (longint'(1) << N);
`else
    if (sm) xi = xi + 0;
`endif
    return W2'(xi * yi);
  endfunction

  // One full transaction; hold = cycles out_ready stays low once out_valid is up.
  task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input logic sm,
                        input int hold, input string tag);
    logic [W2-1:0] exp_v;
    int lat;
    int guard;
    bit busy_seen;
    bit unstable;
    exp_v = ref_product(op_a, op_b, sm);
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check_value({tag, "_in_ready"}, in_ready, 1);
    in_valid    = 1'b1;
    a           = op_a;
    b           = op_b;
    signed_mode = sm;
    out_ready   = (hold == 0);
    tick();
    in_valid    = 1'b0;
    a           = N'($urandom);
    b           = N'($urandom);
    signed_mode = 1'($urandom);
    lat = 1;
    busy_seen = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready) busy_seen = 1;
      tick();
      lat++;
    end
    check_value({tag, "_latency"}, lat, N + 1);
    check_value({tag, "_busy"}, busy_seen, 0);
    check_value({tag, "_out"}, out, exp_v);
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!out_valid || out !== exp_v || in_ready) unstable = 1;
    end
    if (hold > 0) check_value({tag, "_hold"}, unstable, 0);
    out_ready = 1'b1;
    check_value({tag, "_done_in_ready"}, in_ready, 0);
    tick();
    check_value({tag, "_consumed"}, {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] pa [3];
    logic [N-1:0] pb [3];
    logic [W2-1:0] got_q [$];
    int acc_t [3];
    int idx;
    int cyc;
    bit rdy;
    bit vld;
    bit saw_valid;
    logic [W2-1:0] o;

    // Reset state
    tick();
    tick();
    check_value("rst_in_ready", in_ready, 0);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_out", out, 0);
    rst = 1'b0;
    tick();
    check_value("post_rst_in_ready", in_ready, 1);

    // Directed operations
    run_op(4'd13, 4'd11, 1'b0, 0, "u13x11");
    run_op(4'h8, 4'h8, 1'b1, 0, "sneg8xneg8");
    run_op(4'h8, 4'h7, 1'b1, 1, "sneg8x7");
    run_op(4'h0, 4'hF, 1'b1, 2, "s0xneg1");
    run_op(4'hF, 4'hF, 1'b1, 0, "sFxF");
    run_op(4'hF, 4'hF, 1'b0, 10, "backpressure");

    // Reset during the 4th CALC cycle discards the operation
    run_op(4'd1, 4'd1, 1'b0, 0, "pre_rst");
    in_valid = 1'b1;
    a = 4'd10;
    b = 4'd3;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("midrst_out", out, 0);
    check_value("midrst_flags", {in_ready, out_valid}, 2'b00);
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) saw_valid = 1;
    end
    check_value("midrst_no_valid", saw_valid, 0);
    check_value("midrst_out_held", out, 0);
    run_op(4'd7, 4'd6, 1'b0, 0, "after_rst");

    // Back-to-back with in_valid held high
    pa[0] = 4'd3;  pb[0] = 4'd5;
    pa[1] = 4'd15; pb[1] = 4'd0;
    pa[2] = 4'd9;  pb[2] = 4'd9;
    idx = 0;
    cyc = 0;
    out_ready = 1'b1;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    a = pa[0];
    b = pb[0];
    while ((idx < 3 || got_q.size() < 3) && cyc < 60) begin
      rdy = in_ready;
      vld = out_valid;
      o = out;
      tick();
      cyc++;
      if (vld) got_q.push_back(o);
      if (rdy && in_valid) begin
        acc_t[idx] = cyc;
        idx++;
        if (idx < 3) begin
          a = pa[idx];
          b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_value("b2b_count", got_q.size(), 3);
    for (int i = 0; i < got_q.size() && i < 3; i++)
      check_value($sformatf("b2b_out%0d", i), got_q[i], ref_product(pa[i], pb[i], 1'b0));
    if (idx == 3) begin
      check_value("b2b_ii01", acc_t[1] - acc_t[0], N + 2);
      check_value("b2b_ii12", acc_t[2] - acc_t[1], N + 2);
    end

    // Randomised operations
    for (int i = 0; i < 30; i++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
